// File: rtl/bcd_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_arb_pkg                                                   |
// | Purpose  : Shared types and constants for the BCD converter arbiter:     |
// |            FSM state encoding, operand/result widths and the result      |
// |            pattern reported when a conversion is aborted.                |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package bcd_arb_pkg;

  localparam int BIN_W = 12;
  localparam int BCD_W = 16;

  // Returned in place of a result when the converter never answers.
  localparam logic [BCD_W-1:0] ERR_BCD = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                    |
// | Purpose  : Combinational round-robin pick. Searches the request vector   |
// |            starting at the pointer and wrapping, returning the first     |
// |            requester found.                                              |
// | Ports    : req        - request vector                                   |
// |            ptr        - index holding top priority this cycle            |
// |            win_onehot - one-hot winner (zero when nothing requests)      |
// |            win_idx    - index of the winner                              |
// |            any        - at least one request is present                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [IDW-1:0]  win_idx,
  output logic            any
);

  int cand;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any              = 1'b1;
        win_idx          = IDW'(cand);
        win_onehot[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_conv_arbiter                                              |
// | Purpose  : Round-robin scheduler sharing one binary-to-BCD converter     |
// |            among NREQ requesters. Latches the winner's operand, pulses   |
// |            conv_start, waits for conv_ready, then broadcasts the result  |
// |            tagged with the requester index.                              |
// | Config   : define BCD_ARB_TIMEOUT_EN to abort a conversion after         |
// |            TIMEOUT cycles in WAIT (res_err=1, res_bcd=16'hFFFF).         |
// | Ports    : clk, reset (sync, active-high)                                |
// |            req/req_bin          - requests and packed 12-bit operands    |
// |            gnt                  - one-hot grant, START through DONE      |
// |            res_valid/id/bcd/err - result strobe and payload              |
// |            conv_start/binary    - converter command                      |
// |            conv_bcd/ready       - converter response                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BIN_W-1:0]    req_bin,
  output logic [NREQ-1:0]          gnt,
  output logic                     res_valid,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [BCD_W-1:0]         res_bcd,
  output logic                     res_err,
  output logic                     conv_start,
  output logic [BIN_W-1:0]         conv_binary,
  input  logic [BCD_W-1:0]         conv_bcd,
  input  logic                     conv_ready
);

  localparam int IDW = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     win_q, win_d;
  logic               conv_start_q, conv_start_d;
  logic [BIN_W-1:0]   conv_binary_q, conv_binary_d;
  logic               res_valid_q, res_valid_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic [BCD_W-1:0]   res_bcd_q, res_bcd_d;

  logic [NREQ-1:0]    pick_onehot;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  logic [BIN_W-1:0]   bin_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign bin_arr[i] = req_bin[i*BIN_W +: BIN_W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any        (pick_any)
  );

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             res_err_q, res_err_d;
`else
  // TIMEOUT and ERR_BCD only matter when the abort path is built.
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT != 0) ^ (&ERR_BCD);
`endif

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    conv_start_d  = 1'b0;
    conv_binary_d = conv_binary_q;
    res_valid_d   = 1'b0;
    res_id_d      = res_id_q;
    res_bcd_d     = res_bcd_q;
`ifdef BCD_ARB_TIMEOUT_EN
    wcnt_d        = wcnt_q;
    res_err_d     = res_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d         = pick_onehot;
          win_d         = pick_idx;
          conv_binary_d = bin_arr[pick_idx];
          conv_start_d  = 1'b1;
          state_d       = START;
        end
      end
      START: begin
        // conv_ready still reflects the previous conversion here; ignore it.
        state_d = WAIT;
`ifdef BCD_ARB_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      WAIT: begin
        if (conv_ready) begin
          res_bcd_d   = conv_bcd;
          res_valid_d = 1'b1;
          res_id_d    = win_q;
          state_d     = DONE;
`ifdef BCD_ARB_TIMEOUT_EN
          res_err_d   = 1'b0;
        end else if (wcnt_q == CNT_W'(TIMEOUT)) begin
          res_bcd_d   = ERR_BCD;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          res_id_d    = win_q;
          state_d     = DONE;
        end else begin
          wcnt_d      = wcnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      ptr_q         <= '0;
      win_q         <= '0;
      conv_start_q  <= 1'b0;
      conv_binary_q <= '0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_bcd_q     <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
      wcnt_q        <= '0;
      res_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      conv_start_q  <= conv_start_d;
      conv_binary_q <= conv_binary_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_bcd_q     <= res_bcd_d;
`ifdef BCD_ARB_TIMEOUT_EN
      wcnt_q        <= wcnt_d;
      res_err_q     <= res_err_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign conv_start  = conv_start_q;
  assign conv_binary = conv_binary_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_bcd     = res_bcd_q;
`ifdef BCD_ARB_TIMEOUT_EN
  assign res_err     = res_err_q;
`else
  assign res_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bcd_conv_arbiter                                           |
// | Purpose  : Self-checking bench for bcd_conv_arbiter with a converter     |
// |            stub of random latency and a cycle-level reference model.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bcd_conv_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [47:0] req_bin;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [15:0] res_bcd;
  logic        res_err;
  logic        conv_start;
  logic [11:0] conv_binary;
  logic [15:0] conv_bcd;
  logic        conv_ready;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_bin     (req_bin),
    .gnt         (gnt),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_bcd     (res_bcd),
    .res_err     (res_err),
    .conv_start  (conv_start),
    .conv_binary (conv_binary),
    .conv_bcd    (conv_bcd),
    .conv_ready  (conv_ready)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Converter stub: drops ready on the start edge, raises it after a random latency.
  int          lat_min = 0, lat_max = 5;
  bit          stub_low = 1'b0;
  int          cv_cnt;
  bit          cv_busy;
  logic [11:0] cv_val;

  always @(posedge clk) begin
    if (reset) begin
      conv_ready <= 1'b0;
      conv_bcd   <= '0;
      cv_busy    <= 1'b0;
      cv_cnt     <= 0;
    end else if (conv_start) begin
      conv_ready <= 1'b0;
      cv_busy    <= 1'b1;
      cv_cnt     <= $urandom_range(lat_max, lat_min);
      cv_val     <= conv_binary;
    end else if (cv_busy && !stub_low) begin
      if (cv_cnt == 0) begin
        conv_ready <= 1'b1;
        conv_bcd   <= to_bcd(int'(cv_val));
        cv_busy    <= 1'b0;
      end else begin
        cv_cnt <= cv_cnt - 1;
      end
    end
  end

  // Reference model: grant ages, the first ready after the start cycle ends it.
  bit          m_busy, m_fin;
  int          m_age, m_ptr, m_win, pick;
  logic [11:0] m_op;
  logic [3:0]  exp_gnt;
  logic        exp_start, exp_valid, exp_err;
  logic [11:0] exp_bin;
  logic [1:0]  exp_id;
  logic [15:0] exp_bcd;

  always @(posedge clk) begin
    pick = rr_pick(req, m_ptr);
    if (reset) begin
      m_busy <= 0; m_fin <= 0; m_age <= 0; m_ptr <= 0; m_win <= 0; m_op <= '0;
      exp_gnt <= '0; exp_start <= 0; exp_bin <= '0; exp_valid <= 0;
      exp_id <= '0; exp_bcd <= '0; exp_err <= 0;
    end else if (!m_busy) begin
      exp_valid <= 1'b0;
      if (pick >= 0) begin
        m_busy    <= 1'b1;
        m_age     <= 0;
        m_fin     <= 1'b0;
        m_win     <= pick;
        m_op      <= req_bin[pick*12 +: 12];
        exp_gnt   <= 4'(1 << pick);
        exp_start <= 1'b1;
        exp_bin   <= req_bin[pick*12 +: 12];
      end
    end else if (m_fin) begin
      exp_valid <= 1'b0;
      exp_gnt   <= '0;
      m_ptr     <= (m_win + 1) % 4;
      m_busy    <= 1'b0;
      m_fin     <= 1'b0;
    end else begin
      exp_start <= 1'b0;
      m_age     <= m_age + 1;
      if (m_age >= 1 && conv_ready) begin
        exp_valid <= 1'b1;
        exp_id    <= 2'(m_win);
        exp_bcd   <= to_bcd(int'(m_op));
        exp_err   <= 1'b0;
        m_fin     <= 1'b1;
      end
`ifdef BCD_ARB_TIMEOUT_EN
      else if (m_age >= 1 && m_age - 1 == TIMEOUT) begin
        exp_valid <= 1'b1;
        exp_id    <= 2'(m_win);
        exp_bcd   <= 16'hFFFF;
        exp_err   <= 1'b1;
        m_fin     <= 1'b1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("conv_start", 32'(conv_start), 32'(exp_start));
      chk("conv_binary", 32'(conv_binary), 32'(exp_bin));
      chk("res_valid", 32'(res_valid), 32'(exp_valid));
      chk("res_id", 32'(res_id), 32'(exp_id));
      chk("res_bcd", 32'(res_bcd), 32'(exp_bcd));
      chk("res_err", 32'(res_err), 32'(exp_err));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_gnt();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (gnt != 0) return;
    end
    errors++;
    $display("FAIL wait_gnt: got no grant expected one within 50 cycles");
  endtask

  task automatic wait_result(output logic [1:0] id, output logic [15:0] bcd, output logic err);
    id = '0; bcd = '0; err = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (res_valid) begin
        id = res_id; bcd = res_bcd; err = res_err;
        return;
      end
    end
    errors++;
    $display("FAIL wait_result: got no res_valid expected one within 200 cycles");
  endtask

  logic [1:0]  r_id;
  logic [15:0] r_bcd;
  logic        r_err;
  logic [15:0] lits [4];

  initial begin
    reset = 1'b1; req = '0; req_bin = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_conv_binary", 32'(conv_binary), 32'h0);
    chk("rst_res_bcd", 32'(res_bcd), 32'h0);
    reset = 1'b0;

    // single request
    req_bin[11:0] = 12'd123; req = 4'b0001;
    @(negedge clk);
    chk("single_start", 32'(conv_start), 32'h1);
    chk("single_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("single_start_pulse", 32'(conv_start), 32'h0);
    wait_result(r_id, r_bcd, r_err);
    chk("single_id", 32'(r_id), 32'h0);
    chk("single_bcd", 32'(r_bcd), 32'h0123);
    chk("single_err", 32'(r_err), 32'h0);
    req = '0;

    // all four with boundary operands
    do_reset();
    lits = '{16'h0000, 16'h0005, 16'h0123, 16'h4095};
    req_bin = {12'd4095, 12'd123, 12'd5, 12'd0};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_result(r_id, r_bcd, r_err);
      chk("all4_id", 32'(r_id), 32'(k));
      chk("all4_bcd", 32'(r_bcd), 32'(lits[k]));
      req[r_id] = 1'b0;
    end

    // fairness over 8 grants
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_result(r_id, r_bcd, r_err);
      chk("fair_id", 32'(r_id), 32'(k % 4));
    end
    req = '0;

    // operand change and request drop after grant
    do_reset();
    lat_min = 6; lat_max = 8;
    req_bin[35:24] = 12'd42; req = 4'b0100;
    wait_gnt();
    repeat (2) @(negedge clk);
    req_bin[35:24] = 12'd99;
    @(negedge clk);
    req = '0;
    wait_result(r_id, r_bcd, r_err);
    chk("drop_id", 32'(r_id), 32'h2);
    chk("drop_bcd", 32'(r_bcd), 32'h0042);

    // reset in the middle of WAIT
    do_reset();
    lat_min = 10; lat_max = 12;
    req_bin[23:12] = 12'd7; req = 4'b0010;
    wait_gnt();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_valid", 32'(res_valid), 32'h0);
    chk("midrst_start", 32'(conv_start), 32'h0);
    chk("midrst_binary", 32'(conv_binary), 32'h0);
    reset = 1'b0;
    lat_min = 0; lat_max = 5;
    wait_result(r_id, r_bcd, r_err);
    chk("midrst_id", 32'(r_id), 32'h1);
    chk("midrst_bcd", 32'(r_bcd), 32'h0007);
    req = '0;

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (exp_valid && exp_id == 2'(i)) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          req_bin[i*12 +: 12] = 12'($urandom_range(4095, 0));
        end else if (exp_gnt[i] && $urandom_range(15, 0) == 0) req[i] = 1'b0;
        if ($urandom_range(7, 0) == 0) req_bin[i*12 +: 12] = 12'($urandom_range(4095, 0));
      end
    end
    req = '0;
    repeat (40) @(negedge clk);

`ifdef BCD_ARB_TIMEOUT_EN
    // converter never answers
    do_reset();
    stub_low = 1'b1;
    req_bin[11:0] = 12'd777; req = 4'b0001;
    wait_gnt();
    begin
      int cnt;
      cnt = 0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        cnt++;
        if (res_valid) break;
      end
      chk("to_latency", 32'(cnt), 32'd33);
      chk("to_err", 32'(res_err), 32'h1);
      chk("to_bcd", 32'(res_bcd), 32'hFFFF);
    end
    req = '0;
    stub_low = 1'b0;
    req_bin[23:12] = 12'd88; req = 4'b0010;
    wait_result(r_id, r_bcd, r_err);
    chk("to_resume_id", 32'(r_id), 32'h1);
    chk("to_resume_bcd", 32'(r_bcd), 32'h0088);
    req = '0;
    repeat (5) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin scheduler that shares one binary-to-BCD converter (12-bit binary in, 16-bit packed BCD out, start/ready handshake) among `NREQ` requesters.
- Per conversion: latches the granted requester's operand, pulses the converter's start, waits for ready, then broadcasts the result tagged with the requester ID.
- Sits between display/telemetry producers and the single converter instance.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 31: max WAIT cycles before abort; used only with `BCD_ARB_TIMEOUT_EN`.
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, NREQ: request per requester; held until that requester's result is published.
- `req_bin`, in, NREQ*12: operands; slice i = bits [12i+11:12i].
- `gnt`, out, NREQ: one-hot grant, high from START through DONE.
- `res_valid`, out, 1: one-cycle result strobe.
- `res_id`, out, clog2(NREQ): requester index of the result.
- `res_bcd`, out, 16: packed BCD result, held until the next DONE.
- `res_err`, out, 1: timeout abort flag, qualified by `res_valid`.
- `conv_start`, out, 1: one-cycle start pulse to the converter.
- `conv_binary`, out, 12: latched operand, stable from START to DONE.
- `conv_bcd`, in, 16: converter result.
- `conv_ready`, in, 1: converter done level. The converter deasserts it on the edge that samples `conv_start`.

## Operation
- FSM states and transitions:
  - IDLE: if any `req` bit is high, pick the winner, register `gnt` and `conv_binary` from its slice, then go to START.
  - START: `conv_start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: on `conv_ready`=1, capture `conv_bcd` into `res_bcd` and go to DONE.
  - DONE: `res_valid`=1 and `res_id` = winner. Update the pointer to winner+1 mod NREQ, clear `gnt`, return to IDLE.
- Arbitration: round-robin starting at the pointer. After reset the pointer is 0, so index 0 has top priority.
- Requests arriving during START/WAIT/DONE wait; they are evaluated in the next IDLE cycle.
- A `req` bit dropped after grant does not abort the conversion; the result is still published.
- Operand changes on `req_bin` after grant are ignored (latched copy used).
- `req` all-zero: stay in IDLE, all outputs quiescent.
- Simultaneous `req` rise in the same cycle as DONE: not seen until IDLE (one-cycle gap guaranteed).
- Reset values: state IDLE, pointer 0, `gnt`=0, `conv_start`=0, `conv_binary`=0, `res_valid`=0, `res_id`=0, `res_bcd`=0, `res_err`=0.
- Reset mid-operation: the conversion is abandoned with no `res_valid`. The converter shares `reset`, so no stale `conv_ready` survives.

## Timing
- `req` sampled high in IDLE at cycle 0:
  - `gnt` and `conv_binary` valid at cycle 1 (START).
  - `conv_start` high in cycle 1 only.
  - `conv_ready` is ignored in START; it is sampled from cycle 2.
- If `conv_ready` is first seen high at cycle k, `res_valid` is high at cycle k+1.
- Fixed overhead: 3 cycles per grant (IDLE, START, DONE) plus converter latency.
- All outputs are registered; no combinational path from `req` or `conv_ready` to outputs.

## Configuration
- `BCD_ARB_TIMEOUT_EN` defined:
  - A WAIT counter (width clog2(TIMEOUT+1)) clears on entry to WAIT.
  - If it reaches `TIMEOUT` without `conv_ready`, go to DONE with `res_err`=1 and `res_bcd`=16'hFFFF.
  - The pointer still advances.
- Not defined: WAIT is unbounded, `res_err` is tied 0, and no counter is built.

## Structure
- Package `bcd_arb_pkg` holds:
  - FSM state enum (IDLE, START, WAIT, DONE);
  - `BIN_W`=12, `BCD_W`=16;
  - `ERR_BCD`=16'hFFFF.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are `req` and the pointer; outputs are a one-hot winner and its index. Instantiated once.
- Top level holds the FSM, pointer, operand/result registers and the optional timeout counter.

## Test plan
- Single request: `req`=4'b0001, operand 123 → `conv_start` is one pulse in the cycle after the request; then `res_valid` with `res_id`=0, `res_bcd`=16'h0123, `res_err`=0.
- All four requesting, operands 0/5/123/4095 → results in order id 0,1,2,3 with BCD 16'h0000, 16'h0005, 16'h0123, 16'h4095; each `gnt` one-hot and non-overlapping.
- Fairness: `req`=4'b1111 held for 8 grants → id sequence 0,1,2,3,0,1,2,3; no requester is granted twice before the others.
- Operand change and request drop after grant: `req_bin` slice changed from 42 to 99 during WAIT, then `req` dropped → result is 16'h0042 and is still published.
- Reset mid-WAIT: `reset` pulsed for one cycle → next cycle all outputs are at reset values, no `res_valid`, and a fresh request converts correctly.
- With `BCD_ARB_TIMEOUT_EN` and `TIMEOUT`=31, `conv_ready` stubbed low → `res_valid` with `res_err`=1 and `res_bcd`=16'hFFFF exactly 33 cycles after START; arbitration then resumes.
